vga_canvas_ctrl: RTL and testbench
==================================

Name: vga_canvas_ctrl

Overview:
Parametrised VGA timing generator plus a GRID_N x GRID_N 1-bit drawing canvas with cursor overlay, pen/erase writes, bulk-clear sequencer and a row readout port for the classifier. Sits between the mouse cursor accumulator and the VGA pins; the DNN front end reads the canvas through the readout port. Single pixel-clock domain; the caller supplies cursor coordinates already in active-pixel space.

Parameters:
H_SYNC, 128, horizontal sync pulse width (pixels)
H_BP, 88, horizontal back porch
H_ACTIVE, 800, horizontal active pixels
H_FP, 40, horizontal front porch
V_SYNC, 4, vertical sync pulse (lines)
V_BP, 23, vertical back porch
V_ACTIVE, 600, vertical active lines
V_FP, 1, vertical front porch
GRID_N, 32, canvas cells per side
CELL_SHIFT, 4, log2 of cell edge in pixels (cell = 16x16 px)
CURSOR_SIZE, 8, cursor box edge in pixels
COORD_W, 11, width of counters and cursor coordinates

Ports:
iBusClk  in  1  pixel clock (40 MHz for defaults)
iRstN  in  1  asynchronous active-low reset
iCursorX  in  COORD_W  cursor x, active-pixel space
iCursorY  in  COORD_W  cursor y, active-pixel space
iPenDown  in  1  level: set cell under cursor
iErase  in  1  level: clear cell under cursor
iClear  in  1  pulse: start bulk canvas clear
oClearBusy  out  1  high while clear sequencer runs
iRdRow  in  $clog2(GRID_N)  canvas row to read
oRdData  out  GRID_N  row contents, bit c = column c
oRed/oGreen/oBlue  out  4 each  pixel colour
oHs  out  1  horizontal sync, active low
oVs  out  1  vertical sync, active low
oFrameStart  out  1  one-cycle pulse at hCnt==0, vCnt==0

Behaviour:
- Reset (async, iRstN low): hCnt=vCnt=0; canvas all 0; colours 0; oHs=oVs=1; oFrameStart=0; oRdData=0; oClearBusy=0; FSM=IDLE.
- hCnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), wraps to 0; vCnt increments on hCnt wrap, 0..V_TOTAL-1, wraps. Both in iBusClk domain only.
- Sync low when count < SYNC width. Active when hCnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and same for v (exclusive upper bound).
- Pixel x = hCnt-(H_SYNC+H_BP), y likewise. All video outputs (colours, oHs, oVs, oFrameStart) registered: 1-cycle latency, mutually aligned.
- Colour priority: blanking -> 0/0/0; cursor box (cx<=x<cx+CURSOR_SIZE, cy<=y<cy+CURSOR_SIZE) -> iErase blue F/0/0... i.e. R0 G0 BF; else iPenDown green 0/F/0; else red F/0/0; grid area (x,y < GRID_N<<CELL_SHIFT) cell set -> magenta F/0/F, cell clear -> white F/F/F; active outside grid -> grey 8/8/8.
- Cell under cursor: col = iCursorX>>CELL_SHIFT, row = iCursorY>>CELL_SHIFT; write only if both < GRID_N, else no write.
- Write every cycle while enabled: iErase clears cell; iPenDown sets; both high -> erase wins.
- Clear FSM: IDLE --iClear--> CLEARING; CLEARING zeroes row rowIdx per cycle, rowIdx 0..GRID_N-1, then IDLE. oClearBusy high exactly GRID_N cycles starting cycle after iClear. iClear while busy ignored. Pen/erase writes suppressed while busy.
- Readout: oRdData <= canvas[iRdRow] each cycle (1-cycle latency, reflects canvas state before same-cycle write). iRdRow >= GRID_N returns 0.
- Reset mid-clear aborts; canvas reset to 0 anyway.

Optional Feature:
VGA_GRIDLINES_EN: when defined, grid-area pixels with (x or y) low CELL_SHIFT bits ==0 on a clear cell render grey 8/8/8; set cells and cursor unaffected. Undefined: no gridlines, plain white.

Decomposition:
- Package vga_pkg: H/V timing defaults for 800x600@60, 4-bit colour constants (BLACK, WHITE, RED, GREEN, BLUE, MAGENTA, GREY), clear FSM state enum.
- Sub-module vga_timing_gen: hCnt/vCnt, raw sync, active, pixel x/y, frame-start; canvas, FSM, colour mux stay in top.

Test Plan:
- Reset then release -> oHs low 128 cycles per 1056-cycle line; oVs low 4 lines per 628-line frame; oFrameStart one pulse per 663168 cycles.
- Cursor (100,50), iPenDown 1 cycle -> iRdRow=3 gives oRdData bit 6 =1, all other bits 0; pixel (100,50) red... after moving cursor to (700,500), pixel (100,50) magenta.
- Cell (6,3) set, iPenDown and iErase both high at (100,50) -> bit 6 of row 3 cleared.
- Cursor (600,20) with pen down -> no canvas change (col 37 >= 32).
- Fill rows 0 and 31, pulse iClear -> oClearBusy high 32 cycles, pen writes during it ignored, afterwards every row reads 0; second iClear mid-sweep doesn't extend busy.
- Pixel (0,0) with canvas clear and cursor away -> F/F/F; pixel (700,300) -> 8/8/8; blanking -> 0/0/0; with VGA_GRIDLINES_EN pixel (16,5) -> 8/8/8.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA canvas controller: 800x600@60 timing defaults,
// 4-bit-per-channel colour constants and the bulk-clear FSM state type.
package vga_pkg;

    localparam int unsigned DefHSync   = 128;
    localparam int unsigned DefHBp     = 88;
    localparam int unsigned DefHActive = 800;
    localparam int unsigned DefHFp     = 40;
    localparam int unsigned DefVSync   = 4;
    localparam int unsigned DefVBp     = 23;
    localparam int unsigned DefVActive = 600;
    localparam int unsigned DefVFp     = 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t ColBlack   = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t ColWhite   = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t ColRed     = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb_t ColGreen   = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t ColBlue    = '{r: 4'h0, g: 4'h0, b: 4'hF};
    localparam rgb_t ColMagenta = '{r: 4'hF, g: 4'h0, b: 4'hF};
    localparam rgb_t ColGrey    = '{r: 4'h8, g: 4'h8, b: 4'h8};

    typedef enum logic {
        StIdle,
        StClearing
    } clr_state_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with raw (unregistered) sync, active-area,
// pixel-coordinate and frame-start decodes. The top registers everything.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned COORD_W  = 11
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               hs_o,
    output logic               vs_o,
    output logic               active_o,
    output logic               frame_start_o,
    output logic [COORD_W-1:0] px_x_o,
    output logic [COORD_W-1:0] px_y_o
);

    localparam int unsigned HTotal = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned VTotal = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HStart = H_SYNC + H_BP;
    localparam int unsigned VStart = V_SYNC + V_BP;

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

    // Next count: h wraps each line, v advances on h wrap and wraps each frame.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == COORD_W'(HTotal - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == COORD_W'(VTotal - 1)) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Raw decodes from the current counts.
    always_comb begin
        hs_o          = (h_cnt_q >= COORD_W'(H_SYNC));
        vs_o          = (v_cnt_q >= COORD_W'(V_SYNC));
        active_o      = (h_cnt_q >= COORD_W'(HStart)) &&
                        (h_cnt_q <  COORD_W'(HStart + H_ACTIVE)) &&
                        (v_cnt_q >= COORD_W'(VStart)) &&
                        (v_cnt_q <  COORD_W'(VStart + V_ACTIVE));
        frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
        px_x_o        = h_cnt_q - COORD_W'(HStart);
        px_y_o        = v_cnt_q - COORD_W'(VStart);
    end

endmodule

// File: rtl/vga_canvas_ctrl.sv
// VGA timing plus a GRID_N x GRID_N 1-bit canvas with cursor overlay, pen/erase
// writes, a row-per-cycle bulk-clear sequencer and a registered row readout.
// Optional: define VGA_GRIDLINES_EN to draw grey cell borders on clear cells.
module vga_canvas_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC      = DefHSync,
    parameter int unsigned H_BP        = DefHBp,
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned H_FP        = DefHFp,
    parameter int unsigned V_SYNC      = DefVSync,
    parameter int unsigned V_BP        = DefVBp,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned V_FP        = DefVFp,
    parameter int unsigned GRID_N      = 32,
    parameter int unsigned CELL_SHIFT  = 4,
    parameter int unsigned CURSOR_SIZE = 8,
    parameter int unsigned COORD_W     = 11
) (
    input  logic                      iBusClk,
    input  logic                      iRstN,
    input  logic [COORD_W-1:0]        iCursorX,
    input  logic [COORD_W-1:0]        iCursorY,
    input  logic                      iPenDown,
    input  logic                      iErase,
    input  logic                      iClear,
    output logic                      oClearBusy,
    input  logic [$clog2(GRID_N)-1:0] iRdRow,
    output logic [GRID_N-1:0]         oRdData,
    output logic [3:0]                oRed,
    output logic [3:0]                oGreen,
    output logic [3:0]                oBlue,
    output logic                      oHs,
    output logic                      oVs,
    output logic                      oFrameStart
);

    localparam int unsigned RowW  = $clog2(GRID_N);
    localparam int unsigned GridW = GRID_N << CELL_SHIFT;

    logic               hs_raw, vs_raw, active, fs_raw;
    logic [COORD_W-1:0] px_x, px_y;

    vga_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .COORD_W  (COORD_W)
    ) u_timing (
        .clk_i         (iBusClk),
        .rst_ni        (iRstN),
        .hs_o          (hs_raw),
        .vs_o          (vs_raw),
        .active_o      (active),
        .frame_start_o (fs_raw),
        .px_x_o        (px_x),
        .px_y_o        (px_y)
    );

    logic [GRID_N-1:0] canvas_q [GRID_N];
    logic [GRID_N-1:0] canvas_d [GRID_N];
    clr_state_e        state_q, state_d;
    logic [RowW-1:0]   row_idx_q, row_idx_d;
    logic              busy;

    assign busy       = (state_q == StClearing);
    assign oClearBusy = busy;

    // Clear sequencer: one row per cycle, iClear ignored once running.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        unique case (state_q)
            StIdle: begin
                if (iClear) begin
                    state_d   = StClearing;
                    row_idx_d = '0;
                end
            end
            StClearing: begin
                row_idx_d = row_idx_q + 1'b1;
                if (row_idx_q == RowW'(GRID_N - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Cell under the cursor; out-of-range cursor positions write nothing.
    logic [RowW-1:0] cur_col, cur_row;
    logic            cell_ok;
    assign cur_col = iCursorX[CELL_SHIFT +: RowW];
    assign cur_row = iCursorY[CELL_SHIFT +: RowW];
    assign cell_ok = ((iCursorX >> CELL_SHIFT) < COORD_W'(GRID_N)) &&
                     ((iCursorY >> CELL_SHIFT) < COORD_W'(GRID_N));

    // Canvas update: clear sweep has priority and blocks pen/erase; erase beats pen.
    always_comb begin
        canvas_d = canvas_q;
        if (busy) begin
            canvas_d[row_idx_q] = '0;
        end else if (cell_ok && iErase) begin
            canvas_d[cur_row][cur_col] = 1'b0;
        end else if (cell_ok && iPenDown) begin
            canvas_d[cur_row][cur_col] = 1'b1;
        end
    end

    // Pixel colour selection from the current raw timing decode.
    logic [COORD_W:0] box_x_end, box_y_end;
    logic             in_cursor, in_grid, pix_set;
    rgb_t             rgb_d, rgb_q;
    always_comb begin
        box_x_end = {1'b0, iCursorX} + (COORD_W + 1)'(CURSOR_SIZE);
        box_y_end = {1'b0, iCursorY} + (COORD_W + 1)'(CURSOR_SIZE);
        in_cursor = (px_x >= iCursorX) && ({1'b0, px_x} < box_x_end) &&
                    (px_y >= iCursorY) && ({1'b0, px_y} < box_y_end);
        in_grid   = (px_x < COORD_W'(GridW)) && (px_y < COORD_W'(GridW));
        pix_set   = canvas_q[px_y[CELL_SHIFT +: RowW]][px_x[CELL_SHIFT +: RowW]];
        rgb_d     = ColBlack;
        if (!active) begin
            rgb_d = ColBlack;
        end else if (in_cursor) begin
            rgb_d = iErase ? ColBlue : (iPenDown ? ColGreen : ColRed);
        end else if (in_grid) begin
            if (pix_set) begin
                rgb_d = ColMagenta;
            end else begin
`ifdef VGA_GRIDLINES_EN
                rgb_d = ((px_x[CELL_SHIFT-1:0] == '0) || (px_y[CELL_SHIFT-1:0] == '0)) ?
                        ColGrey : ColWhite;
`else
                rgb_d = ColWhite;
`endif
            end
        end else begin
            rgb_d = ColGrey;
        end
    end

    // Canvas, FSM, readout and video output registers.
    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            canvas_q    <= '{default: '0};
            state_q     <= StIdle;
            row_idx_q   <= '0;
            oRdData     <= '0;
            rgb_q       <= ColBlack;
            oHs         <= 1'b1;
            oVs         <= 1'b1;
            oFrameStart <= 1'b0;
        end else begin
            canvas_q    <= canvas_d;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            oRdData     <= ({1'b0, iRdRow} < (RowW + 1)'(GRID_N)) ? canvas_q[iRdRow] : '0;
            rgb_q       <= rgb_d;
            oHs         <= hs_raw;
            oVs         <= vs_raw;
            oFrameStart <= fs_raw;
        end
    end

    assign oRed   = rgb_q.r;
    assign oGreen = rgb_q.g;
    assign oBlue  = rgb_q.b;

endmodule

// File: tb/tb_vga_canvas_ctrl.sv
// Directed bench for vga_canvas_ctrl using a reduced timing set so frames are short.
// Pixel checks come from a vector table; writes, clear and timing are hand sequences.
module tb_vga_canvas_ctrl;

    localparam int HS = 4, HBP = 3, HA = 40, HFP = 2;
    localparam int VS = 2, VBP = 2, VA = 36, VFP = 1;
    localparam int HTOT = HS + HBP + HA + HFP;   // 49
    localparam int VTOT = VS + VBP + VA + VFP;   // 41
    localparam int FRAME = HTOT * VTOT;          // 2009
    localparam int HB = HS + HBP;
    localparam int VB = VS + VBP;
    localparam int GN = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] iCursorX = '0, iCursorY = '0;
    logic        iPenDown = 1'b0, iErase = 1'b0, iClear = 1'b0;
    logic        oClearBusy;
    logic [2:0]  iRdRow = '0;
    logic [7:0]  oRdData;
    logic [3:0]  oRed, oGreen, oBlue;
    logic        oHs, oVs, oFrameStart;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vga_canvas_ctrl #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .GRID_N(GN), .CELL_SHIFT(2), .CURSOR_SIZE(4), .COORD_W(11)
    ) dut (
        .iBusClk(clk), .iRstN(rst_n),
        .iCursorX(iCursorX), .iCursorY(iCursorY),
        .iPenDown(iPenDown), .iErase(iErase), .iClear(iClear),
        .oClearBusy(oClearBusy), .iRdRow(iRdRow), .oRdData(oRdData),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oHs(oHs), .oVs(oVs), .oFrameStart(oFrameStart)
    );

    typedef struct {
        string       name;
        logic [10:0] cx;
        logic [10:0] cy;
        logic        pen;
        logic        er;
        int          h;
        int          v;
        logic [11:0] rgb;
    } pix_vec_t;

    pix_vec_t tab[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic pix_vec_t mk(input string n, input int cx, input int cy, input logic p,
                                    input logic e, input int h, input int v,
                                    input logic [11:0] rgb);
        pix_vec_t t;
        t.name = n; t.cx = 11'(cx); t.cy = 11'(cy); t.pen = p; t.er = e;
        t.h = h; t.v = v; t.rgb = rgb;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the sample where oFrameStart is high; bounded to two frames.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (oFrameStart) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("frame_start_timeout", {31'd0, oFrameStart}, 32'd1);
    endtask

    task automatic pen_pulse(input int x, input int y, input logic p, input logic e);
        iCursorX = 11'(x); iCursorY = 11'(y); iPenDown = p; iErase = e;
        tick();
        iPenDown = 1'b0; iErase = 1'b0;
    endtask

    task automatic read_row(input int r, output logic [7:0] d);
        iRdRow = 3'(r);
        tick();
        d = oRdData;
    endtask

    initial begin
        bit          ok;
        int          cnt, cnt2;
        logic [7:0]  d;
        logic [11:0] gl;

`ifdef VGA_GRIDLINES_EN
        gl = 12'h888;
`else
        gl = 12'hFFF;
`endif
        tab[0]  = mk("cursor_red",      13,  6, 0, 0, HB + 13, VB + 6,  12'hF00);
        tab[1]  = mk("cell_magenta",    36, 30, 0, 0, HB + 13, VB + 6,  12'hF0F);
        tab[2]  = mk("clear_white",     36, 30, 0, 0, HB + 5,  VB + 5,  12'hFFF);
        tab[3]  = mk("origin_pixel",    36, 30, 0, 0, HB + 0,  VB + 0,  gl);
        tab[4]  = mk("gridline_pixel",  36, 30, 0, 0, HB + 4,  VB + 1,  gl);
        tab[5]  = mk("set_cell_corner", 36, 30, 0, 0, HB + 12, VB + 4,  12'hF0F);
        tab[6]  = mk("outside_grid",    36, 30, 0, 0, HB + 37, VB + 10, 12'h888);
        tab[7]  = mk("blank_origin",    36, 30, 0, 0, 0,       0,       12'h000);
        tab[8]  = mk("blank_h_fp",      36, 30, 0, 0, HB + HA, VB + 5,  12'h000);
        tab[9]  = mk("blank_v_fp",      36, 30, 0, 0, HB + 20, VB + VA, 12'h000);
        tab[10] = mk("cursor_green",    34, 20, 1, 0, HB + 35, VB + 21, 12'h0F0);
        tab[11] = mk("cursor_blue_end", 34, 20, 0, 1, HB + 37, VB + 23, 12'h00F);
        tab[12] = mk("cursor_both",     34, 20, 1, 1, HB + 34, VB + 20, 12'h00F);
        tab[13] = mk("cursor_edge_red", 30, 30, 0, 0, HB + 33, VB + 33, 12'hF00);
        tab[14] = mk("past_cursor",     30, 30, 0, 0, HB + 34, VB + 30, 12'h888);
        tab[15] = mk("above_cursor",    30, 30, 0, 0, HB + 31, VB + 29, 12'hFFF);

        // Reset values.
        #23;
        check("rst_hs", {31'd0, oHs}, 32'd1);
        check("rst_vs", {31'd0, oVs}, 32'd1);
        check("rst_fs", {31'd0, oFrameStart}, 32'd0);
        check("rst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'd0);
        check("rst_rd", {24'd0, oRdData}, 32'd0);
        check("rst_busy", {31'd0, oClearBusy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Sync and frame-start timing over one line and one frame.
        wait_frame(ok);
        cnt = 0;
        for (int i = 0; i < HTOT; i++) begin
            if (!oHs) cnt++;
            tick();
        end
        check("hs_low_per_line", 32'(cnt), 32'(HS));
        wait_frame(ok);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!oVs) cnt++;
            if (oFrameStart) cnt2++;
            tick();
        end
        check("vs_low_per_frame", 32'(cnt), 32'(VS * HTOT));
        check("fs_per_frame", 32'(cnt2), 32'd1);

        // Pen at (13,6) sets cell col 3 row 1.
        pen_pulse(13, 6, 1'b1, 1'b0);
        read_row(1, d);
        check("pen_row1", {24'd0, d}, 32'h08);
        read_row(0, d);
        check("pen_row0", {24'd0, d}, 32'h00);

        // Pixel vectors.
        for (int i = 0; i < 16; i++) begin
            iCursorX = tab[i].cx; iCursorY = tab[i].cy;
            iPenDown = tab[i].pen; iErase = tab[i].er;
            wait_frame(ok);
            repeat (tab[i].v * HTOT + tab[i].h) @(posedge clk);
            #1;
            check(tab[i].name, {20'd0, oRed, oGreen, oBlue}, {20'd0, tab[i].rgb});
        end
        iPenDown = 1'b0; iErase = 1'b0;

        // Out-of-range pens during the table must not have written anything.
        read_row(1, d);
        check("row1_after_table", {24'd0, d}, 32'h08);

        // Pen and erase together: erase wins.
        pen_pulse(13, 6, 1'b1, 1'b1);
        read_row(1, d);
        check("both_erase_row1", {24'd0, d}, 32'h00);

        // Column 9 is off the canvas: no write.
        pen_pulse(38, 3, 1'b1, 1'b0);
        read_row(0, d);
        check("oob_row0", {24'd0, d}, 32'h00);

        // Fill rows 0 and 7, then sweep-clear with pen held and a second iClear.
        pen_pulse(0, 0, 1'b1, 1'b0);
        pen_pulse(28, 28, 1'b1, 1'b0);
        read_row(0, d);
        check("fill_row0", {24'd0, d}, 32'h01);
        read_row(7, d);
        check("fill_row7", {24'd0, d}, 32'h80);
        check("busy_before", {31'd0, oClearBusy}, 32'd0);
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        check("busy_first", {31'd0, oClearBusy}, 32'd1);
        iCursorX = 11'd13; iCursorY = 11'd6; iPenDown = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (oClearBusy) cnt++;
            iClear = (i == 3);
            if (i == 5) iPenDown = 1'b0;
            tick();
        end
        iClear = 1'b0;
        check("busy_cycles", 32'(cnt), 32'(GN));
        for (int r = 0; r < GN; r++) begin
            read_row(r, d);
            check($sformatf("cleared_row%0d", r), {24'd0, d}, 32'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
